// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling FSM,
// registered byte/valid/frame-error outputs with break detection.
module uart_rx #(
  parameter int CLKS_PER_BIT = 414
) (
  input  logic       CLKIN,
  input  logic       RESETN,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  logic             rx_meta_r;
  logic             rx_sync_r;
  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [2:0]       idx_r, idx_s;
  logic [7:0]       sh_r, sh_s;
  logic [7:0]       data_r, data_s;
  logic             valid_r, valid_s;
  logic             ferr_r, ferr_s;
  logic             busy_r, busy_s;

  // Bring the asynchronous line into the CLKIN domain; idles high.
  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // State and output registers.
  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      idx_r   <= 3'd0;
      sh_r    <= 8'h00;
      data_r  <= 8'h00;
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      sh_r    <= sh_s;
      data_r  <= data_s;
      valid_r <= valid_s;
      ferr_r  <= ferr_s;
      busy_r  <= busy_s;
    end
  end

  // Next-state logic: bit timing, data capture and framing decisions.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    sh_s    = sh_r;
    case (state_r)
      IDLE: begin
        if (!rx_sync_r) begin
          state_s = START;
          cnt_s   = '0;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == CNT_HALF) begin
          cnt_s = '0;
          if (!rx_sync_r) begin
            state_s = DATA;
            idx_s   = 3'd0;
          end else begin
            state_s = IDLE;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s       = '0;
          sh_s[idx_r] = rx_sync_r;
          if (idx_r == 3'd7) begin
            state_s = STOP;
          end else begin
            idx_s = idx_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s   = '0;
          state_s = rx_sync_r ? IDLE : BRK;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      BRK: begin
        // One frame error per low period: stay here until the line recovers.
        if (rx_sync_r) begin
          state_s = IDLE;
        end else begin
          state_s = BRK;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
        idx_s   = 3'd0;
      end
    endcase
  end

  // Output decode: strobes come from the stop-bit sample edge.
  always_comb begin
    data_s  = data_r;
    valid_s = 1'b0;
    ferr_s  = 1'b0;
    busy_s  = (state_s != IDLE);
    if ((state_r == STOP) && (cnt_r == CNT_LAST)) begin
      if (rx_sync_r) begin
        valid_s = 1'b1;
        data_s  = sh_r;
      end else begin
        ferr_s = 1'b1;
      end
    end else begin
      valid_s = 1'b0;
    end
  end

  assign data      = data_r;
  assign valid     = valid_r;
  assign frame_err = ferr_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a 16-cycle instance for function and
// framing, and a default 414-cycle instance for baud tolerance.
module tb_uart_rx;

  localparam int P16  = 16;
  localparam int H16  = P16 / 2;
  localparam int P414 = 414;
  localparam int H414 = P414 / 2;

  logic       CLKIN = 1'b0;
  logic       RESETN;
  logic       rx16, rx414;
  logic [7:0] data16, data414;
  logic       valid16, valid414, ferr16, ferr414, busy16, busy414;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int both_cnt = 0;
  int busy16_cnt = 0;

  int         v16_t[$];
  logic [7:0] v16_d[$];
  int         fe16_t[$];
  int         v414_t[$];
  logic [7:0] v414_d[$];
  int         fe414_t[$];

  logic [7:0] last16;

  uart_rx #(.CLKS_PER_BIT(P16)) dut16 (
    .CLKIN(CLKIN), .RESETN(RESETN), .rx(rx16), .data(data16),
    .valid(valid16), .frame_err(ferr16), .busy(busy16)
  );

  uart_rx dut414 (
    .CLKIN(CLKIN), .RESETN(RESETN), .rx(rx414), .data(data414),
    .valid(valid414), .frame_err(ferr414), .busy(busy414)
  );

  always #5 CLKIN = ~CLKIN;

  always @(posedge CLKIN) cyc <= cyc + 1;

  // Record strobes with the cycle of the edge that raised them.
  always @(negedge CLKIN) begin
    if (valid16) begin v16_t.push_back(cyc); v16_d.push_back(data16); end
    if (ferr16) fe16_t.push_back(cyc);
    if (valid414) begin v414_t.push_back(cyc); v414_d.push_back(data414); end
    if (ferr414) fe414_t.push_back(cyc);
    if ((valid16 && ferr16) || (valid414 && ferr414)) both_cnt++;
    if (busy16) busy16_cnt++;
  end

  task automatic clear_logs();
    v16_t.delete(); v16_d.delete(); fe16_t.delete();
    v414_t.delete(); v414_d.delete(); fe414_t.delete();
    busy16_cnt = 0;
  endtask

  task automatic hold(input int which, input logic v, input int n);
    if (which == 16) rx16 = v; else rx414 = v;
    repeat (n) begin @(posedge CLKIN); #1; end
  endtask

  task automatic send(input int which, input logic [7:0] d, input logic stop,
                      input int p, output int t0);
    t0 = cyc;
    hold(which, 1'b0, p);
    for (int i = 0; i < 8; i++) hold(which, d[i], p);
    hold(which, stop, p);
  endtask

  task automatic test_reset();
    n_checks++; if (data16 !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", data16); end
    n_checks++; if ({valid16, ferr16, busy16} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes: got %b want 000", {valid16, ferr16, busy16}); end
    n_checks++; if ({data414, valid414, ferr414, busy414} !== 11'h000) begin n_fail++; $display("FAIL reset_414: got %h want 000", {data414, valid414, ferr414, busy414}); end
    RESETN = 1'b1;
    hold(16, 1'b1, 20);
    n_checks++; if ({busy16, busy414} !== 2'b00) begin n_fail++; $display("FAIL idle_busy: got %b want 00", {busy16, busy414}); end
    last16 = 8'h00;
  endtask

  task automatic test_single();
    int t0, lat;
    clear_logs();
    send(16, 8'h55, 1'b1, P16, t0);
    hold(16, 1'b1, 2 * P16);
    n_checks++; if (v16_t.size() !== 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", v16_t.size()); end
    if (v16_t.size() > 0) begin
      lat = v16_t[0] - t0;
      n_checks++; if (lat < 2 + H16 + 9 * P16 || lat > 3 + H16 + 9 * P16) begin n_fail++; $display("FAIL single_latency: got %0d want %0d..%0d", lat, 2 + H16 + 9 * P16, 3 + H16 + 9 * P16); end
      n_checks++; if (v16_d[0] !== 8'h55) begin n_fail++; $display("FAIL single_data: got %h want 55", v16_d[0]); end
    end
    n_checks++; if (fe16_t.size() !== 0) begin n_fail++; $display("FAIL single_ferr: got %0d want 0", fe16_t.size()); end
    n_checks++; if (busy16_cnt !== H16 + 9 * P16) begin n_fail++; $display("FAIL single_busy: got %0d want %0d", busy16_cnt, H16 + 9 * P16); end
    last16 = 8'h55;
  endtask

  task automatic test_random();
    int t0s[6];
    logic [7:0] ds[6];
    int lat;
    clear_logs();
    for (int i = 0; i < 6; i++) begin
      ds[i] = 8'($urandom);
      hold(16, 1'b1, $urandom_range(0, 40));
      send(16, ds[i], 1'b1, P16, t0s[i]);
    end
    hold(16, 1'b1, 2 * P16);
    n_checks++; if (v16_t.size() !== 6) begin n_fail++; $display("FAIL random_count: got %0d want 6", v16_t.size()); end
    for (int i = 0; i < 6 && i < v16_t.size(); i++) begin
      lat = v16_t[i] - t0s[i];
      n_checks++; if (v16_d[i] !== ds[i]) begin n_fail++; $display("FAIL random_data%0d: got %h want %h", i, v16_d[i], ds[i]); end
      n_checks++; if (lat < 2 + H16 + 9 * P16 || lat > 3 + H16 + 9 * P16) begin n_fail++; $display("FAIL random_latency%0d: got %0d want %0d..%0d", i, lat, 2 + H16 + 9 * P16, 3 + H16 + 9 * P16); end
    end
    n_checks++; if (fe16_t.size() !== 0) begin n_fail++; $display("FAIL random_ferr: got %0d want 0", fe16_t.size()); end
    last16 = ds[5];
  endtask

  task automatic test_back_to_back();
    int t0a, t0b;
    clear_logs();
    send(16, 8'hA3, 1'b1, P16, t0a);
    send(16, 8'h0F, 1'b1, P16, t0b);
    hold(16, 1'b1, 2 * P16);
    n_checks++; if (v16_t.size() !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", v16_t.size()); end
    if (v16_t.size() == 2) begin
      n_checks++; if (v16_t[1] - v16_t[0] !== 10 * P16) begin n_fail++; $display("FAIL b2b_spacing: got %0d want %0d", v16_t[1] - v16_t[0], 10 * P16); end
      n_checks++; if ({v16_d[0], v16_d[1]} !== 16'hA30F) begin n_fail++; $display("FAIL b2b_data: got %h%h want a30f", v16_d[0], v16_d[1]); end
    end
    n_checks++; if (data16 !== 8'h0F) begin n_fail++; $display("FAIL b2b_hold: got %h want 0f", data16); end
    last16 = 8'h0F;
  endtask

  task automatic test_glitch();
    clear_logs();
    hold(16, 1'b0, 5);
    hold(16, 1'b1, 3 * P16);
    n_checks++; if (v16_t.size() + fe16_t.size() !== 0) begin n_fail++; $display("FAIL glitch_strobes: got %0d want 0", v16_t.size() + fe16_t.size()); end
    n_checks++; if (busy16_cnt > H16 + 1 || busy16_cnt < 1) begin n_fail++; $display("FAIL glitch_busy: got %0d want 1..%0d", busy16_cnt, H16 + 1); end
    n_checks++; if (data16 !== last16) begin n_fail++; $display("FAIL glitch_data: got %h want %h", data16, last16); end
  endtask

  task automatic test_frame_err();
    int t0, lat;
    clear_logs();
    send(16, 8'h3C, 1'b0, P16, t0);
    hold(16, 1'b0, 20 * P16);
    n_checks++; if (busy16 !== 1'b1) begin n_fail++; $display("FAIL break_busy: got %b want 1", busy16); end
    hold(16, 1'b1, P16);
    n_checks++; if (busy16 !== 1'b0) begin n_fail++; $display("FAIL break_exit: got %b want 0", busy16); end
    n_checks++; if (fe16_t.size() !== 1) begin n_fail++; $display("FAIL ferr_count: got %0d want 1", fe16_t.size()); end
    if (fe16_t.size() > 0) begin
      lat = fe16_t[0] - t0;
      n_checks++; if (lat < 2 + H16 + 9 * P16 || lat > 3 + H16 + 9 * P16) begin n_fail++; $display("FAIL ferr_latency: got %0d want %0d..%0d", lat, 2 + H16 + 9 * P16, 3 + H16 + 9 * P16); end
    end
    n_checks++; if (v16_t.size() !== 0) begin n_fail++; $display("FAIL ferr_valid: got %0d want 0", v16_t.size()); end
    n_checks++; if (data16 !== last16) begin n_fail++; $display("FAIL ferr_data: got %h want %h", data16, last16); end
    send(16, 8'h81, 1'b1, P16, t0);
    hold(16, 1'b1, 2 * P16);
    n_checks++; if (v16_t.size() !== 1 || data16 !== 8'h81) begin n_fail++; $display("FAIL ferr_recover: got %0d/%h want 1/81", v16_t.size(), data16); end
    n_checks++; if (fe16_t.size() !== 1) begin n_fail++; $display("FAIL ferr_single: got %0d want 1", fe16_t.size()); end
    last16 = 8'h81;
  endtask

  task automatic test_mid_reset();
    logic [7:0] d;
    int t0;
    clear_logs();
    d = 8'h5A;
    hold(16, 1'b0, P16);
    for (int i = 0; i < 4; i++) hold(16, d[i], P16);
    hold(16, d[4], H16);
    RESETN = 1'b0;
    #2;
    n_checks++; if ({data16, valid16, ferr16, busy16} !== 11'h000) begin n_fail++; $display("FAIL midreset_outputs: got %h want 000", {data16, valid16, ferr16, busy16}); end
    rx16 = 1'b1;
    repeat (3) @(posedge CLKIN);
    #1;
    RESETN = 1'b1;
    hold(16, 1'b1, 2 * P16);
    n_checks++; if (v16_t.size() + fe16_t.size() !== 0) begin n_fail++; $display("FAIL midreset_strobe: got %0d want 0", v16_t.size() + fe16_t.size()); end
    send(16, 8'hFF, 1'b1, P16, t0);
    hold(16, 1'b1, 2 * P16);
    n_checks++; if (v16_t.size() !== 1 || data16 !== 8'hFF) begin n_fail++; $display("FAIL midreset_next: got %0d/%h want 1/ff", v16_t.size(), data16); end
    last16 = 8'hFF;
  endtask

  task automatic test_reset_low_line();
    logic [7:0] d;
    int t0, lat;
    clear_logs();
    d = 8'($urandom);
    RESETN = 1'b0;
    rx16 = 1'b0;
    repeat (2) @(posedge CLKIN);
    #1;
    RESETN = 1'b1;
    send(16, d, 1'b1, P16, t0);
    hold(16, 1'b1, 2 * P16);
    n_checks++; if (v16_t.size() !== 1 || data16 !== d) begin n_fail++; $display("FAIL lowline_frame: got %0d/%h want 1/%h", v16_t.size(), data16, d); end
    if (v16_t.size() > 0) begin
      lat = v16_t[0] - t0;
      n_checks++; if (lat < 2 + H16 + 9 * P16 || lat > 3 + H16 + 9 * P16) begin n_fail++; $display("FAIL lowline_latency: got %0d want %0d..%0d", lat, 2 + H16 + 9 * P16, 3 + H16 + 9 * P16); end
    end
    last16 = d;
  endtask

  task automatic test_baud_mismatch();
    int t0;
    logic [7:0] d;
    clear_logs();
    send(414, 8'hC9, 1'b1, 430, t0);
    hold(414, 1'b1, 430);
    n_checks++; if (v414_t.size() !== 1 || data414 !== 8'hC9) begin n_fail++; $display("FAIL slow_baud: got %0d/%h want 1/c9", v414_t.size(), data414); end
    n_checks++; if (fe414_t.size() !== 0) begin n_fail++; $display("FAIL slow_baud_ferr: got %0d want 0", fe414_t.size()); end
    clear_logs();
    d = 8'($urandom);
    send(414, d, 1'b1, 398, t0);
    hold(414, 1'b1, 430);
    n_checks++; if (v414_t.size() !== 1 || data414 !== d || fe414_t.size() !== 0) begin n_fail++; $display("FAIL fast_baud: got %0d/%h/%0d want 1/%h/0", v414_t.size(), data414, fe414_t.size(), d); end
  endtask

  task automatic test_exclusive();
    n_checks++; if (both_cnt !== 0) begin n_fail++; $display("FAIL strobe_overlap: got %0d want 0", both_cnt); end
  endtask

  initial begin
    RESETN = 1'b0;
    rx16   = 1'b1;
    rx414  = 1'b1;
    repeat (3) @(posedge CLKIN);
    #1;
    test_reset();
    test_single();
    test_random();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_mid_reset();
    test_reset_low_line();
    test_baud_mismatch();
    test_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
